// File: rtl/insn_fetch_unit.sv
// insn_fetch_unit
//   Owns the program counter for a 4-phase sequenced CPU (fetch -> decode ->
//   exec -> rdmem). Captures the instruction word during fetch, applies
//   branches during exec, substitutes NOP bubbles when fetch is stalled, and
//   raises a sticky error when the phase inputs are not exactly one-hot.
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   phase_fetch/decode/exec/rdmem  one-hot sequencer phase
//   stall                       bubble instead of fetch (fetch phase only)
//   branch_en, branch_target    load new PC (exec phase only)
//   imem_addr                   instruction memory address (= pc)
//   imem_data                   instruction memory read data
//   insn, insn_pc, insn_valid   held instruction, its address, real/bubble
//   pc                          next fetch address
//   phase_err                   sticky illegal-phase flag
module insn_fetch_unit #(
  parameter int unsigned          PC_W     = 16,
  parameter int unsigned          INSN_W   = 18,
  parameter logic [PC_W-1:0]      RESET_PC = 'h0100,
  parameter logic [INSN_W-1:0]    NOP_INSN = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              phase_fetch,
  input  logic              phase_decode,
  input  logic              phase_exec,
  input  logic              phase_rdmem,
  input  logic              stall,
  input  logic              branch_en,
  input  logic [PC_W-1:0]   branch_target,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [INSN_W-1:0] imem_data,
  output logic [INSN_W-1:0] insn,
  output logic [PC_W-1:0]   insn_pc,
  output logic              insn_valid,
  output logic [PC_W-1:0]   pc,
  output logic              phase_err
);

  logic [PC_W-1:0]   pc_q,      pc_d;
  logic [INSN_W-1:0] insn_q,    insn_d;
  logic [PC_W-1:0]   insn_pc_q, insn_pc_d;
  logic              valid_q,   valid_d;
  logic              err_q,     err_d;

  logic [3:0] phase_vec;
  logic       phase_ok;

  assign phase_vec = {phase_fetch, phase_decode, phase_exec, phase_rdmem};
  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  assign phase_ok  = (phase_vec != '0) && ((phase_vec & (phase_vec - 4'd1)) == '0);

  always_comb begin
    pc_d      = pc_q;
    insn_d    = insn_q;
    insn_pc_d = insn_pc_q;
    valid_d   = valid_q;
    err_d     = err_q;
    if (!phase_ok) begin
      // Illegal encoding blocks any capture or branch this edge.
      err_d = 1'b1;
    end else if (phase_fetch) begin
      if (stall) begin
        insn_d  = NOP_INSN;
        valid_d = 1'b0;
      end else begin
        insn_d    = imem_data;
        insn_pc_d = pc_q;
        pc_d      = pc_q + PC_W'(1);
        valid_d   = 1'b1;
      end
    end else if (phase_exec && branch_en) begin
      pc_d = branch_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      insn_q    <= NOP_INSN;
      insn_pc_q <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      insn_q    <= insn_d;
      insn_pc_q <= insn_pc_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign insn       = insn_q;
  assign insn_pc    = insn_pc_q;
  assign insn_valid = valid_q;
  assign phase_err  = err_q;

endmodule
